// File: rtl/univ_shift_seq_pkg.sv
// Shared encodings for the universal shift register sequencer: register
// control codes and sequencer state codes.
package univ_shift_seq_pkg;

  localparam logic [1:0] SR_LOAD = 2'b00;
  localparam logic [1:0] SR_SHR  = 2'b01;
  localparam logic [1:0] SR_SHL  = 2'b10;
  localparam logic [1:0] SR_HOLD = 2'b11;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_LOAD  = 3'd1;
  localparam state_t ST_BIT   = 3'd2;
  localparam state_t ST_SHIFT = 3'd3;
  localparam state_t ST_DONE  = 3'd4;
  localparam state_t ST_CLR   = 3'd5;

endpackage

// File: rtl/univ_shift_seq.sv
// Serialises a parallel word by sequencing an external universal shift register:
// load, hold each bit for div+1 cycles, shift, and clear on completion or abort.
module univ_shift_seq
  import univ_shift_seq_pkg::*;
#(
  parameter int unsigned DW = 4,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          async_rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic          s_dir,
  input  logic [CW-1:0] s_div,
  input  logic          s_fill,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          sr_sync_rst,
  output logic [1:0]    sr_ctrl,
  output logic [DW-1:0] sr_data,
  output logic          sr_data_l,
  output logic          sr_data_h,
  input  logic [DW-1:0] sr_q,
  output logic          ser_out,
  output logic          ser_valid
);

  localparam int unsigned BW = (DW > 2) ? $clog2(DW) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DW - 1);

  state_t        state_q, state_d;
  logic [DW-1:0] word_q;
  logic          dir_q;
  logic [CW-1:0] div_q;
  logic          fill_q;
  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic          accept;
  logic          tap;
  logic          unused_sr;

  assign s_ready = (state_q == ST_IDLE) && !abort;
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        state_d   = ST_BIT;
        div_cnt_d = '0;
        bit_cnt_d = '0;
      end
      ST_BIT: begin
        // Equality compare lets div = 2^CW-1 work without a wider counter.
        if (div_cnt_q == div_q) begin
          state_d = (bit_cnt_q == LAST_BIT) ? ST_DONE : ST_SHIFT;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        state_d   = ST_BIT;
        bit_cnt_d = bit_cnt_q + 1'b1;
        div_cnt_d = '0;
      end
      ST_DONE: state_d = ST_IDLE;
      ST_CLR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort && (state_q != ST_IDLE) && (state_q != ST_CLR)) state_d = ST_CLR;
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q   <= ST_IDLE;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      word_q <= '0;
      dir_q  <= 1'b0;
      div_q  <= '0;
      fill_q <= 1'b0;
    end else if (accept) begin
      word_q <= s_data;
      dir_q  <= s_dir;
      div_q  <= s_div;
      fill_q <= s_fill;
    end
  end

  assign tap       = dir_q ? sr_q[0] : sr_q[DW-1];
  // Only the two end taps matter; the rest of the register is observed externally.
  assign unused_sr = ^sr_q;

  always_comb begin
    busy        = (state_q != ST_IDLE);
    done        = (state_q == ST_DONE) && !abort;
    sr_sync_rst = (state_q == ST_DONE) || (state_q == ST_CLR);
    ser_valid   = (state_q == ST_BIT);
    ser_out     = ser_valid & tap;
    sr_data     = word_q;
    sr_data_l   = fill_q;
    sr_data_h   = fill_q;
    sr_ctrl     = SR_HOLD;
    if (state_q == ST_LOAD)  sr_ctrl = SR_LOAD;
    if (state_q == ST_SHIFT) sr_ctrl = dir_q ? SR_SHR : SR_SHL;
  end

endmodule

// File: tb/tb_univ_shift_seq.sv
// Bench for univ_shift_seq: stand-in shift register, randomized words with a
// queue-based scoreboard of expected serial bits, register contents and done latency.
module tb_univ_shift_seq;

  localparam int unsigned DW = 4;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          async_rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_dir = 1'b0;
  logic [CW-1:0] s_div = '0;
  logic          s_fill = 1'b0;
  logic          abort = 1'b0;
  logic          busy, done, sr_sync_rst;
  logic [1:0]    sr_ctrl;
  logic [DW-1:0] sr_data;
  logic          sr_data_l, sr_data_h;
  logic [DW-1:0] sr_q = '0;
  logic          ser_out, ser_valid;

  always #5 clk = ~clk;

  univ_shift_seq #(.DW(DW), .CW(CW)) dut (
    .clk        (clk),
    .async_rst_n(async_rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_dir      (s_dir),
    .s_div      (s_div),
    .s_fill     (s_fill),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .sr_sync_rst(sr_sync_rst),
    .sr_ctrl    (sr_ctrl),
    .sr_data    (sr_data),
    .sr_data_l  (sr_data_l),
    .sr_data_h  (sr_data_h),
    .sr_q       (sr_q),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid)
  );

  // Universal shift register with synchronous active-high clear.
  always @(posedge clk) begin
    if (sr_sync_rst) sr_q <= '0;
    else begin
      case (sr_ctrl)
        2'b00:   sr_q <= sr_data;
        2'b01:   sr_q <= {sr_data_h, sr_q[DW-1:1]};
        2'b10:   sr_q <= {sr_q[DW-2:0], sr_data_l};
        default: sr_q <= sr_q;
      endcase
    end
  end

  typedef struct {
    logic          b;
    logic [DW-1:0] q;
  } ser_exp_t;

  ser_exp_t ser_q[$];
  int       done_q[$];
  int       n_vec = 0;
  int       n_err = 0;
  int       cyc = 0;
  int       acc_cyc = 0;
  bit       clr_pend = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Register contents after i shifts, from the load word and fill bit.
  function automatic logic [DW-1:0] qexp(input logic [DW-1:0] d, input logic dr,
                                          input logic f, input int i);
    logic [DW-1:0] ones;
    ones = '1;
    if (dr) return (d >> i) | (f ? ~(ones >> i) : '0);
    else    return (d << i) | (f ? ~(ones << i) : '0);
  endfunction

  // ab = cycle (relative to accept) in which abort is raised, 0 = none.
  task automatic push_exp(input logic [DW-1:0] d, input logic dr, input int dv,
                          input logic f, input int ab);
    ser_exp_t e;
    int t;
    int total;
    total = 2 + DW * (dv + 1) + (DW - 1);
    for (int i = 0; i < DW; i++) begin
      for (int j = 0; j <= dv; j++) begin
        t = 2 + i * (dv + 2) + j;
        if (ab == 0 || t <= ab) begin
          e.b = dr ? d[i] : d[DW-1-i];
          e.q = qexp(d, dr, f, i);
          ser_q.push_back(e);
        end
      end
    end
    if (ab == 0) done_q.push_back(total);
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard queues.
  initial begin
    ser_exp_t e;
    int lat;
    forever begin
      @(negedge clk);
      if (clr_pend) begin
        chk("sr_q_cleared", 32'(sr_q), 32'd0);
        clr_pend = 1'b0;
      end
      if (async_rst_n) begin
        if (s_valid && s_ready) acc_cyc = cyc;
        if (ser_valid) begin
          if (ser_q.size() == 0) note_fail("unexpected_ser_valid");
          else begin
            e = ser_q.pop_front();
            chk("ser_out", 32'(ser_out), 32'(e.b));
            chk("sr_q_bit", 32'(sr_q), 32'(e.q));
          end
        end
        if (done) begin
          if (done_q.size() == 0) note_fail("unexpected_done");
          else begin
            lat = done_q.pop_front();
            chk("done_latency", 32'(cyc - acc_cyc), 32'(lat));
          end
        end
        if (sr_sync_rst) clr_pend = 1'b1;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of cycle 1 (or the CLR cycle).
  task automatic issue(input logic [DW-1:0] d, input logic dr, input int dv, input logic f,
                       input int ab, output int waited);
    s_valid = 1'b1;
    s_data  = d;
    s_dir   = dr;
    s_div   = CW'(dv);
    s_fill  = f;
    waited  = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!s_ready && waited < 5000);
    if (!s_ready) begin
      note_fail("accept_timeout");
      s_valid = 1'b0;
      return;
    end
    push_exp(d, dr, dv, f, ab);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_data  = DW'($urandom);
    s_dir   = 1'($urandom);
    s_div   = CW'($urandom);
    s_fill  = 1'($urandom);
    if (ab > 0) begin
      repeat (ab - 1) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 3000);
    if (busy) note_fail("idle_timeout");
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int dv;
    int total;
    int ab;
    logic [DW-1:0] d;
    logic dr, f;

    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sync_rst", 32'(sr_sync_rst), 32'd0);
    chk("rst_sr_ctrl", 32'(sr_ctrl), 32'd3);
    chk("rst_sr_data", 32'(sr_data), 32'd0);
    chk("rst_fill", 32'({sr_data_l, sr_data_h}), 32'd0);
    chk("rst_ser_valid", 32'(ser_valid), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1 async_rst_n = 1'b1;
    @(posedge clk);
    #1;

    // MSB-first, then LSB-first with fill, then programmable hold.
    issue(4'b1011, 1'b0, 0, 1'b0, 0, w);
    wait_idle();
    issue(4'b1011, 1'b1, 0, 1'b1, 0, w);
    wait_idle();
    issue(4'b0110, 1'b0, 2, 1'b0, 0, w);
    wait_idle();

    // Abort in the second BIT cycle.
    issue(4'b1101, 1'b0, 0, 1'b1, 4, w);
    wait_idle();

    // Abort while idle blocks acceptance.
    s_valid = 1'b1;
    s_data  = 4'b0101;
    abort   = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("s_ready_abort", 32'(s_ready), 32'd0);
      chk("busy_abort_idle", 32'(busy), 32'd0);
    end
    @(posedge clk);
    #1;
    abort   = 1'b0;
    s_valid = 1'b0;

    // Back-to-back words: second accepted in the IDLE cycle right after DONE.
    issue(4'b1000, 1'b0, 0, 1'b0, 0, w);
    issue(4'b0001, 1'b0, 0, 1'b0, 0, w);
    chk("b2b_accept_wait", 32'(w), 32'd10);
    wait_idle();

    // Largest hold count.
    issue(4'b1001, 1'b1, 255, 1'b0, 0, w);
    wait_idle();

    // Asynchronous reset during SHIFT.
    issue(4'b1011, 1'b0, 0, 1'b0, 0, w);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("shift_sr_ctrl", 32'(sr_ctrl), 32'd2);
    #1 async_rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ser_valid", 32'(ser_valid), 32'd0);
    chk("arst_sr_ctrl", 32'(sr_ctrl), 32'd3);
    chk("arst_sr_data", 32'(sr_data), 32'd0);
    chk("arst_sync_rst", 32'({sr_sync_rst, done, sr_data_l}), 32'd0);
    ser_q.delete();
    done_q.delete();
    clr_pend = 1'b0;
    #1 async_rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(4'b0111, 1'b1, 1, 1'b1, 0, w);
    wait_idle();

    // Randomized words with occasional aborts and back-to-back issue.
    for (int n = 0; n < 30; n++) begin
      d     = DW'($urandom);
      dr    = 1'($urandom);
      f     = 1'($urandom);
      dv    = int'($urandom_range(0, 5));
      total = 2 + DW * (dv + 1) + (DW - 1);
      ab    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, total)) : 0;
      issue(d, dr, dv, f, ab, w);
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();
    repeat (3) @(negedge clk);
    chk("ser_queue_drained", 32'(ser_q.size()), 32'd0);
    chk("done_queue_drained", 32'(done_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/univ_shift_seq.md
Name: univ_shift_seq

Overview:
Sequencer that turns a parallel word into a timed serial bit stream by driving an external universal shift register (4-way control: load / shift-right / shift-left / hold, synchronous clear).
- Accepts a word on a valid/ready handshake and issues load, hold and shift commands, with programmable hold cycles per bit.
- Presents the current tap bit as a serial output and clears the register when the word finishes or is aborted.
- Sits between a word producer and one shift-register instance; owns every control input of that register.

Parameters:
DW, 4, data width of word and shift register (>=2)
CW, 8, width of bit-period divider

Ports:
clk  in  1  system clock, rising edge
async_rst_n  in  1  asynchronous active-low reset
s_valid  in  1  word offered
s_ready  out  1  word accepted when s_valid&&s_ready
s_data  in  DW  parallel word
s_dir  in  1  0=MSB-first (shift left), 1=LSB-first (shift right)
s_div  in  CW  extra hold cycles per bit
s_fill  in  1  bit shifted into vacated end
abort  in  1  cancel current word
busy  out  1  word in progress
done  out  1  1-cycle pulse at normal completion
sr_sync_rst  out  1  to register sync clear
sr_ctrl  out  2  00 load, 01 shift right (sr_data_h->MSB), 10 shift left (sr_data_l->LSB), 11 hold
sr_data  out  DW  parallel load value
sr_data_l  out  1  LSB fill
sr_data_h  out  1  MSB fill
sr_q  in  DW  register contents
ser_out  out  1  serial bit
ser_valid  out  1  ser_out meaningful

Behaviour:
- Reset values: state IDLE, busy 0, done 0, sr_sync_rst 0, sr_ctrl 11, sr_data 0, sr_data_l/h 0, ser_valid 0, counters 0.
- On accept, latch s_data, s_dir, s_div, s_fill. Inputs are ignored at all other times.
- s_ready is 1 only in IDLE with abort=0. This is combinational from state and abort.
- sr_data_l = sr_data_h = latched fill. sr_data = latched word, held until the next accept.
- IDLE: sr_ctrl 11. Accept -> LOAD.
- LOAD, 1 cycle: sr_ctrl 00, busy 1. Next state is BIT with bit_cnt=0 and div_cnt=0.
- BIT: sr_ctrl 11, ser_valid 1. ser_out = sr_q[DW-1] if dir=0, sr_q[0] if dir=1.
  - Stays div+1 cycles; div_cnt counts 0..div.
  - When div_cnt==div: if bit_cnt==DW-1 -> DONE, else -> SHIFT.
- SHIFT, 1 cycle: sr_ctrl 10 (dir=0) or 01 (dir=1), ser_valid 0. bit_cnt++, div_cnt=0, -> BIT.
- DONE, 1 cycle: done 1, sr_sync_rst 1, sr_ctrl 11, busy 1. -> IDLE.
- Timing: accept in cycle 0 gives DONE in cycle 2 + DW*(div+1) + (DW-1).
- s_div=0: one cycle per bit in BIT. Maximum s_div = 2^CW-1; no wrap issue because div_cnt is CW bits and compares for equality.
- Abort in LOAD/BIT/SHIFT/DONE -> CLR for 1 cycle: sr_sync_rst 1, sr_ctrl 11, busy 1, done 0, ser_valid 0. Then -> IDLE.
  - Abort overrides the DONE pulse in the same cycle.
  - Abort in IDLE is ignored, except that it blocks acceptance.
- busy = (state != IDLE).
- Async reset mid-word returns to IDLE immediately. The block does not clear the register; the register's own reset domain handles that.

Decomposition:
- Shared package: sr_ctrl encodings (SR_LOAD=2'b00, SR_SHR=2'b01, SR_SHL=2'b10, SR_HOLD=2'b11) and the state enum (IDLE, LOAD, BIT, SHIFT, DONE, CLR).
- Sub-modules: none required. The bench instantiates the existing universal shift register (sync_rst active-high) connected to the sr_* ports and sr_q.

Test Plan:
- DW=4, div=0, data 4'b1011, dir 0, fill 0, accept at cycle 0 -> LOAD cycle 1; ser_out 1,0,1,1 in cycles 2,4,6,8; SHIFT in cycles 3,5,7 with sr_ctrl 10; done in cycle 9; s_ready back in cycle 10.
- Same word with dir 1, fill 1 -> ser_out 1,1,0,1; sr_ctrl 01 on shifts; sr_q after the third shift = 4'b1111; sr_q = 0 after DONE.
- div=2, data 4'b0110, dir 0 -> each bit held 3 cycles with ser_valid high; done in cycle 17; busy high cycles 1..17.
- Abort asserted in the second BIT cycle -> CLR next cycle with sr_sync_rst 1 and no done pulse; IDLE after; sr_q=0; s_ready=0 while abort=1.
- Back-to-back words (s_valid held high, 4'b1000 then 4'b0001, dir 0) -> second word accepted in the cycle after DONE; ser_out 1,0,0,0 then 0,0,0,1; no bubble beyond the IDLE cycle.
- async_rst_n pulsed low during SHIFT -> all outputs go to their reset values asynchronously; after release the block accepts a new word normally.
